wb_decoder_n: RTL
=================

Name: wb_decoder_n

Overview:
- Parametrised 1-master to N-slave Wishbone (classic) address decoder/router; successor to the hard-wired SoC-level stb/ack/data muxing.
- Sits between the arbiter's slave-side port and the peripheral/memory slaves.
- Adds three behaviours the hard-wired muxing lacks: per-transaction latched slave select, an error response for unmapped addresses, and a per-transaction ack timeout.

Parameters:
- NUM_SLAVES, 4, number of slave ports (1..16).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- SEL_WIDTH, DATA_WIDTH/8, byte-select width.
- SLAVE_BASE, {NUM_SLAVES*ADDR_WIDTH}, flattened base addresses; slave i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- SLAVE_MASK, {NUM_SLAVES*ADDR_WIDTH}, flattened decode masks, same layout as SLAVE_BASE.
- TIMEOUT_CYCLES, 256, maximum wait cycles for a slave ack; 0 disables the timeout.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_n_i  in  1  reset; one clock, asynchronous, active-low.
- m_adr_i  in  ADDR_WIDTH  master address.
- m_dat_i  in  DATA_WIDTH  master write data.
- m_dat_o  out  DATA_WIDTH  read data from the selected slave.
- m_we_i  in  1  write enable.
- m_sel_i  in  SEL_WIDTH  byte selects.
- m_cyc_i  in  1  cycle.
- m_stb_i  in  1  strobe.
- m_ack_o  out  1  ack.
- m_err_o  out  1  bus error (unmapped address, timeout, or slave error).
- s_adr_o  out  ADDR_WIDTH  broadcast address.
- s_dat_o  out  DATA_WIDTH  broadcast write data.
- s_we_o  out  1  broadcast we.
- s_sel_o  out  SEL_WIDTH  broadcast sel.
- s_cyc_o  out  NUM_SLAVES  per-slave cyc.
- s_stb_o  out  NUM_SLAVES  per-slave stb.
- s_dat_i  in  NUM_SLAVES*DATA_WIDTH  flattened slave read data.
- s_ack_i  in  NUM_SLAVES  slave acks.
- s_err_i  in  NUM_SLAVES  slave errors.

Behaviour:
- Decode (combinational): hit[i] = ((m_adr_i & MASK[i]) == BASE[i]). The lowest index among hits wins. No hit = miss.
- Broadcast: s_adr_o/s_dat_o/s_we_o/s_sel_o are direct passthroughs of the master inputs.
- FSM states: IDLE, ACTIVE, ERR. Reset state is IDLE; sel_idx=0; tmr=0.
- IDLE:
  - On m_cyc_i & m_stb_i with a hit: latch sel_idx, clear tmr, go to ACTIVE.
  - On m_cyc_i & m_stb_i with a miss: go to ERR.
  - All s_cyc_o/s_stb_o are 0 while in IDLE. Request-to-slave-strobe latency is 1 cycle.
- ACTIVE:
  - s_cyc_o[sel_idx] = s_stb_o[sel_idx] = m_stb_i & m_cyc_i.
  - m_ack_o = s_ack_i[sel_idx] (combinational). m_err_o = s_err_i[sel_idx].
  - m_dat_o = s_dat_i[sel_idx] (combinational).
  - If ack or err: go to IDLE next cycle.
  - Else tmr increments. If TIMEOUT_CYCLES≠0 and tmr==TIMEOUT_CYCLES-1: go to ERR and drop the slave strobe.
- ERR:
  - m_err_o=1 for exactly one cycle; m_ack_o=0; m_dat_o=0.
  - No slave strobe is asserted. Next state is IDLE.
- m_dat_o is 0 outside ACTIVE.
- Master drops m_cyc_i in ACTIVE or ERR: abort, go to IDLE next cycle, slave strobes deassert combinationally. No ack/err is presented once cyc is low.
- sel_idx is held for the whole transaction; address changes during ACTIVE do not re-route.
- Simultaneous slave ack and err: err takes priority; m_ack_o=0.
- Back-to-back transactions: a new request is accepted the cycle after a return to IDLE (minimum 3-cycle transaction).
- tmr width is clog2(TIMEOUT_CYCLES+1); tmr saturates and never wraps.
- Reset asserted mid-transaction: asynchronous return to IDLE; all outputs 0 immediately.
- Overlapping maps are legal (priority rule above). A NUM_SLAVES of 1 must elaborate.

Optional Feature:
- Macro: WB_DECODER_ERRLOG_EN.
- Defined: adds output ports err_adr_o[ADDR_WIDTH], err_cause_o[1:0] (1=unmapped, 2=timeout, 3=slave err) and err_cnt_o[15:0].
  - err_adr_o/err_cause_o capture on each error.
  - err_cnt_o saturates at 16'hFFFF.
  - All three reset to 0.
- Undefined: the ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header wb_decoder_defs.vh holds:
  - the FSM state encodings (IDLE=2'd0, ACTIVE=2'd1, ERR=2'd2);
  - the err_cause codes;
  - a clog2 helper function.
- One natural sub-module, wb_addr_match: a combinational priority decoder that outputs hit and idx. It is reusable by a future multi-master crossbar.

Test Plan:
- NUM_SLAVES=4, BASE={0x0,0x10000000,0x20000000,0x40000000}, MASK=0xF0000000. Read 0x10000004 with slave1 acking after 2 wait states, data 0xDEADBEEF -> s_stb_o=4'b0010 from cycle 1; m_ack_o with m_dat_o=0xDEADBEEF in cycle 3; m_err_o=0 throughout.
- Write 0x30000000 (unmapped) -> no s_stb_o; m_err_o=1 for exactly 1 cycle at cycle 1; FSM back in IDLE at cycle 2.
- TIMEOUT_CYCLES=8, slave2 never acks -> m_err_o pulses 1 cycle after 8 ACTIVE cycles; s_stb_o[2] is low in the ERR cycle; with ERRLOG, err_cause_o=2 and err_adr_o=0x20000000.
- Master drops m_cyc_i 1 cycle into ACTIVE -> s_cyc_o=0 combinationally; IDLE next cycle; no m_ack_o/m_err_o.
- Overlap: slave0 and slave3 both match 0x40000000 with slave0 MASK=0 -> slave0 is selected; slave3 strobe is never raised.
- wb_rst_n_i low mid-ACTIVE, between clock edges -> all s_stb_o/m_ack_o = 0 immediately; after release, a new request succeeds.

Source files
------------

// File: rtl/wb_decoder_n_pkg.sv
// Shared definitions for the wb_decoder_n Wishbone address decoder/router:
// FSM state encodings, error-cause codes and a constant-width helper.
package wb_decoder_n_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_ERR    = 2'd2;

  localparam logic [1:0] CAUSE_UNMAPPED = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
  localparam logic [1:0] CAUSE_SLAVE    = 2'd3;

  // Ceiling log2 for elaboration-time width calculation.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_decoder_n_addr_match.sv
// Combinational priority address decoder: lowest-index matching region wins.
module wb_addr_match #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned IDX_W      = 2,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0
) (
  input  logic [ADDR_WIDTH-1:0] adr,
  output logic                  hit,
  output logic [IDX_W-1:0]      idx
);

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
      if ((adr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/wb_decoder_n.sv
// 1-master to N-slave Wishbone classic decoder with latched routing, unmapped
// error and ack timeout. Optional error log enabled by WB_DECODER_ERRLOG_EN.
module wb_decoder_n
  import wb_decoder_n_pkg::*;
#(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned SEL_WIDTH      = DATA_WIDTH / 8,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {4{32'hF000_0000}},
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_n_i,
  input  logic [ADDR_WIDTH-1:0]            m_adr_i,
  input  logic [DATA_WIDTH-1:0]            m_dat_i,
  output logic [DATA_WIDTH-1:0]            m_dat_o,
  input  logic                             m_we_i,
  input  logic [SEL_WIDTH-1:0]             m_sel_i,
  input  logic                             m_cyc_i,
  input  logic                             m_stb_i,
  output logic                             m_ack_o,
  output logic                             m_err_o,
  output logic [ADDR_WIDTH-1:0]            s_adr_o,
  output logic [DATA_WIDTH-1:0]            s_dat_o,
  output logic                             s_we_o,
  output logic [SEL_WIDTH-1:0]             s_sel_o,
  output logic [NUM_SLAVES-1:0]            s_cyc_o,
  output logic [NUM_SLAVES-1:0]            s_stb_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]            s_ack_i,
  input  logic [NUM_SLAVES-1:0]            s_err_i
`ifdef WB_DECODER_ERRLOG_EN
  ,
  output logic [ADDR_WIDTH-1:0]            err_adr_o,
  output logic [1:0]                       err_cause_o,
  output logic [15:0]                      err_cnt_o
`endif
);

  localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? clog2(NUM_SLAVES) : 1;
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 0) ? clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [1:0]            state_q, state_d;
  logic [IDX_W-1:0]      sel_idx_q, sel_idx_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic                  hit;
  logic [IDX_W-1:0]      hit_idx;
  logic                  req;
  logic                  timeout_hit;
  logic [NUM_SLAVES-1:0] sel_oh;
  logic [DATA_WIDTH-1:0] sel_dat;
  logic                  sel_ack, sel_err;

  assign s_adr_o = m_adr_i;
  assign s_dat_o = m_dat_i;
  assign s_we_o  = m_we_i;
  assign s_sel_o = m_sel_i;

  assign req         = m_cyc_i & m_stb_i;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));

  wb_addr_match #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .IDX_W      (IDX_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_match (
    .adr (m_adr_i),
    .hit (hit),
    .idx (hit_idx)
  );

  // One-hot of the latched slave and the response signals it selects.
  always_comb begin
    sel_oh  = '0;
    sel_dat = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      sel_oh[i] = (sel_idx_q == IDX_W'(i));
      sel_dat   = sel_dat | (s_dat_i[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{sel_oh[i]}});
    end
  end

  assign sel_ack = |(s_ack_i & sel_oh);
  assign sel_err = |(s_err_i & sel_oh);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= ST_IDLE;
      sel_idx_q <= '0;
      tmr_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_idx_q <= sel_idx_d;
      tmr_q     <= tmr_d;
    end
  end

  // Next state and master/slave handshake; responses only while cyc is high.
  always_comb begin
    state_d   = state_q;
    sel_idx_d = sel_idx_q;
    tmr_d     = tmr_q;
    s_cyc_o   = '0;
    s_stb_o   = '0;
    m_ack_o   = 1'b0;
    m_err_o   = 1'b0;
    m_dat_o   = '0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (hit) begin
            state_d   = ST_ACTIVE;
            sel_idx_d = hit_idx;
            tmr_d     = '0;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_ACTIVE: begin
        s_cyc_o = sel_oh & {NUM_SLAVES{req}};
        s_stb_o = sel_oh & {NUM_SLAVES{req}};
        m_dat_o = sel_dat;
        m_err_o = m_cyc_i & sel_err;
        m_ack_o = m_cyc_i & sel_ack & ~sel_err;
        if (!m_cyc_i || sel_ack || sel_err) begin
          state_d = ST_IDLE;
        end else if (timeout_hit) begin
          state_d = ST_ERR;
        end else if (tmr_q != '1) begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_ERR: begin
        m_err_o = m_cyc_i;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef WB_DECODER_ERRLOG_EN
  logic [ADDR_WIDTH-1:0] req_adr_q;
  logic                  timeout_q;
  logic [1:0]            cause_c;

  // ERR entered from ACTIVE is a timeout, from IDLE an unmapped address.
  always_comb begin
    cause_c = CAUSE_SLAVE;
    if (state_q == ST_ERR) cause_c = timeout_q ? CAUSE_TIMEOUT : CAUSE_UNMAPPED;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      req_adr_q   <= '0;
      timeout_q   <= 1'b0;
      err_adr_o   <= '0;
      err_cause_o <= '0;
      err_cnt_o   <= '0;
    end else begin
      if (state_q == ST_IDLE && req) req_adr_q <= m_adr_i;
      timeout_q <= (state_q == ST_ACTIVE) && (state_d == ST_ERR);
      if (m_err_o) begin
        err_adr_o   <= req_adr_q;
        err_cause_o <= cause_c;
        if (err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
      end
    end
  end
`endif

endmodule
